// File: rtl/pipe_scoreboard_pkg.sv
// pipe_scoreboard_pkg
//   Shared configuration and types for the register scoreboard.
//   NUM_REGS     architectural registers tracked (register 0 is never tracked)
//   REG_ADDR_W   register address width
//   LAT_MAX      largest result latency, issue to forwardable
//   LAT_W        width of a latency value (holds 0..LAT_MAX)
//   FLUSH_DEPTH  entries younger than this many cycles are squashed on flush
//   AGE_W        width of the saturating age counter (holds 0..FLUSH_DEPTH)
//   sb_entry_t   per-register state {busy, cnt, age}
//   sb_issue_t   bundle of the decode-side fields
//   sat_lat()    clamps a requested latency to LAT_MAX
package pipe_scoreboard_pkg;

  localparam int NUM_REGS    = 32;
  localparam int REG_ADDR_W  = $clog2(NUM_REGS);
  localparam int LAT_MAX     = 4;
  localparam int LAT_W       = $clog2(LAT_MAX + 1);
  localparam int FLUSH_DEPTH = 2;
  localparam int AGE_W       = $clog2(FLUSH_DEPTH + 1);

  typedef struct packed {
    logic             busy;
    logic [LAT_W-1:0] cnt;
    logic [AGE_W-1:0] age;
  } sb_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic [LAT_W-1:0]      lat;
  } sb_issue_t;

  function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
    if (lat > LAT_W'(LAT_MAX)) return LAT_W'(LAT_MAX);
    return lat;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_sb_entry.sv
// pipe_scoreboard_sb_entry
//   State of one tracked architectural register.
//   clk, rst  clock, asynchronous active-high reset
//   issue     an instruction writing this register fires this cycle
//   lat       its (already clamped) latency
//   commit    WriteBack commits this register this cycle
//   flush     pipeline flush; squashes this entry if it is still young
//   busy      a write to this register is in flight
//   cnt       cycles left until the in-flight value is forwardable
// Priority: issue > (commit | young flush) > countdown/aging.
// Issue and flush never coincide because issue is suppressed on flush.
module pipe_scoreboard_sb_entry
  import pipe_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [LAT_W-1:0] lat,
  input  logic             commit,
  input  logic             flush,
  output logic             busy,
  output logic [LAT_W-1:0] cnt
);

  sb_entry_t q;
  logic      young;

  assign young = (q.age < AGE_W'(FLUSH_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (issue) begin
      q.busy <= 1'b1;
      q.cnt  <= lat;
      q.age  <= '0;
    end else if (q.busy) begin
      if (commit || (flush && young)) begin
        q <= '0;
      end else begin
        if (q.cnt != '0) q.cnt <= q.cnt - 1'b1;
        if (young)       q.age <= q.age + 1'b1;
      end
    end
  end

  assign busy = q.busy;
  assign cnt  = q.cnt;

endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Register scoreboard / hazard controller between Decode and Execute.
//   Tracks in-flight register writes, stalls decode on RAW/WAW hazards,
//   flags bypassable operands and squashes young entries on flush.
//   Configuration constants live in pipe_scoreboard_pkg.
//
//   Handshake: decode offers an instruction with dec_valid; it is accepted
//   in a cycle where issue_fire=1 (dec_valid & ~issue_stall & ~flush).
//   While issue_stall=1 decode must hold the same instruction stable.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     dec_*             decode instruction fields (sources, dest, latency)
//     wb_valid, wb_rd   WriteBack commit of one register
//     flush             branch/exception flush
//     issue_stall       decode must hold
//     issue_fire        instruction accepted this cycle
//     fwd_rs1/fwd_rs2   operand must come from the bypass network
//     perf_stall_cnt    stall cycle counter
//
//   Optional build macro SCOREBOARD_PERF_EN: when defined, perf_stall_cnt
//   counts stall cycles (wrapping at 2^32); otherwise it is tied to 0.
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_rd_we,
  input  logic [LAT_W-1:0]      dec_lat,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  issue_stall,
  output logic                  issue_fire,
  output logic                  fwd_rs1,
  output logic                  fwd_rs2,
  output logic [31:0]           perf_stall_cnt
);

  sb_issue_t        dec;
  logic [LAT_W-1:0] lat_sat;
  logic             busy [NUM_REGS];
  logic [LAT_W-1:0] cnt  [NUM_REGS];
  logic             raw1, raw2, waw;

  assign dec = '{valid: dec_valid, rs1: dec_rs1, rs2: dec_rs2,
                 rs1_used: dec_rs1_used, rs2_used: dec_rs2_used,
                 rd: dec_rd, rd_we: dec_rd_we, lat: dec_lat};

  assign lat_sat = sat_lat(dec.lat);

  // Register 0 is hard-wired: never busy, so it never stalls or forwards.
  assign busy[0] = 1'b0;
  assign cnt[0]  = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic issue_i, commit_i;
    assign issue_i  = issue_fire && dec.rd_we && (dec.rd == REG_ADDR_W'(i));
    assign commit_i = wb_valid && (wb_rd == REG_ADDR_W'(i));
    pipe_scoreboard_sb_entry u_entry (
      .clk    (clk),
      .rst    (rst),
      .issue  (issue_i),
      .lat    (lat_sat),
      .commit (commit_i),
      .flush  (flush),
      .busy   (busy[i]),
      .cnt    (cnt[i])
    );
  end

  // Hazards use registered state only; same-cycle commit/flush do not bypass.
  assign raw1 = dec.rs1_used && (dec.rs1 != '0) && busy[dec.rs1] && (cnt[dec.rs1] != '0);
  assign raw2 = dec.rs2_used && (dec.rs2 != '0) && busy[dec.rs2] && (cnt[dec.rs2] != '0);
  assign waw  = dec.rd_we && (dec.rd != '0) && busy[dec.rd];

  assign issue_stall = dec.valid && (raw1 || raw2 || waw);
  assign issue_fire  = dec.valid && !issue_stall && !flush;
  assign fwd_rs1 = dec.valid && dec.rs1_used && (dec.rs1 != '0) && busy[dec.rs1] && (cnt[dec.rs1] == '0);
  assign fwd_rs2 = dec.valid && dec.rs2_used && (dec.rs2 != '0) && busy[dec.rs2] && (cnt[dec.rs2] == '0);

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              perf_q <= '0;
    else if (issue_stall) perf_q <= perf_q + 32'd1;
  end
  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

  // Latencies above LAT_MAX are clamped in hardware but indicate a decode bug.
  a_lat_range : assert property (@(posedge clk) disable iff (rst)
    !(dec_valid && dec_rd_we && (dec_lat > LAT_W'(LAT_MAX))));

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;
  import pipe_scoreboard_pkg::*;

  logic                  clk, rst;
  logic                  dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_we;
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic [LAT_W-1:0]      dec_lat;
  logic                  wb_valid, flush;
  logic                  issue_stall, issue_fire, fwd_rs1, fwd_rs2;
  logic [31:0]           perf_stall_cnt;
  logic [3:0]            obs;
  int                    n_vec = 0;
  int                    n_bad = 0;

  pipe_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd),
    .dec_rd_we(dec_rd_we), .dec_lat(dec_lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .issue_stall(issue_stall), .issue_fire(issue_fire),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .perf_stall_cnt(perf_stall_cnt)
  );

  // {stall, fire, fwd1, fwd2}
  assign obs = {issue_stall, issue_fire, fwd_rs1, fwd_rs2};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_rd = 0; dec_rd_we = 0; dec_lat = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic set_dec(input logic [REG_ADDR_W-1:0] rs1, input logic u1,
                         input logic [REG_ADDR_W-1:0] rs2, input logic u2,
                         input logic [REG_ADDR_W-1:0] rd, input logic we,
                         input logic [LAT_W-1:0] lat);
    dec_valid = 1; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    dec_rd = rd; dec_rd_we = we; dec_lat = lat;
  endtask

  task automatic set_wb(input logic [REG_ADDR_W-1:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // scenarios
  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    n_vec++; if (obs !== 4'b0000) begin n_bad++; $display("FAIL reset_outs got=%b want=0000", obs); end
    n_vec++; if (perf_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_perf got=%0d want=0", perf_stall_cnt); end
    rst = 0;
    tick();
    set_dec(0, 0, 0, 0, 5, 1, 3);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL rst_issue5 got=%b want=0100", obs); end
    tick();
    set_dec(5, 1, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (obs !== 4'b1000) begin n_bad++; $display("FAIL rst_pre_stall got=%b want=1000", obs); end
    rst = 1;  // asynchronous, mid-cycle
    #1;
    n_vec++; if ({issue_stall, fwd_rs1} !== 2'b00) begin n_bad++; $display("FAIL rst_async_clear got=%b want=00", {issue_stall, fwd_rs1}); end
    idle();
    tick();
    rst = 0;
  endtask

  task automatic test_raw();
    do_reset();
    set_dec(0, 0, 0, 0, 5, 1, 2);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL raw_issue got=%b want=0100", obs); end
    tick();
    set_dec(5, 1, 5, 1, 0, 0, 0);
    #1;
    n_vec++; if (obs !== 4'b1000) begin n_bad++; $display("FAIL raw_c1 got=%b want=1000", obs); end
    tick();
    n_vec++; if (obs !== 4'b1000) begin n_bad++; $display("FAIL raw_c2 got=%b want=1000", obs); end
    tick();
    n_vec++; if (obs !== 4'b0111) begin n_bad++; $display("FAIL raw_c3_fwd got=%b want=0111", obs); end
    set_wb(5);
    #1;
    n_vec++; if (obs !== 4'b0111) begin n_bad++; $display("FAIL raw_wb_no_bypass got=%b want=0111", obs); end
    tick();
    wb_valid = 0;
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL raw_after_wb got=%b want=0100", obs); end
    idle();
  endtask

  task automatic test_waw();
    do_reset();
    set_dec(0, 0, 0, 0, 7, 1, 0);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL waw_issue got=%b want=0100", obs); end
    tick();
    set_dec(7, 1, 0, 0, 7, 1, 1);
    #1;
    n_vec++; if (obs !== 4'b1010) begin n_bad++; $display("FAIL waw_stall1 got=%b want=1010", obs); end
    tick();
    n_vec++; if (obs !== 4'b1010) begin n_bad++; $display("FAIL waw_stall2 got=%b want=1010", obs); end
    set_wb(7);
    #1;
    n_vec++; if (obs !== 4'b1010) begin n_bad++; $display("FAIL waw_commit_cycle got=%b want=1010", obs); end
    tick();
    wb_valid = 0;
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL waw_fire_after got=%b want=0100", obs); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_dec(0, 0, 0, 0, 3, 1, 1);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL fl_issue3 got=%b want=0100", obs); end
    tick();
    idle();
    tick();
    set_dec(0, 0, 0, 0, 4, 1, 1);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL fl_issue4 got=%b want=0100", obs); end
    tick();
    set_dec(0, 0, 0, 0, 9, 1, 0);
    flush = 1;
    #1;
    n_vec++; if (obs !== 4'b0000) begin n_bad++; $display("FAIL fl_fire_suppressed got=%b want=0000", obs); end
    tick();
    flush = 0;
    set_dec(0, 0, 0, 0, 4, 1, 0);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL fl_rd4_squashed got=%b want=0100", obs); end
    set_dec(0, 0, 0, 0, 9, 1, 0);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL fl_rd9_not_issued got=%b want=0100", obs); end
    set_dec(0, 0, 0, 0, 3, 1, 0);
    #1;
    n_vec++; if (obs !== 4'b1000) begin n_bad++; $display("FAIL fl_rd3_kept got=%b want=1000", obs); end
    set_dec(3, 1, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (obs !== 4'b0110) begin n_bad++; $display("FAIL fl_rd3_fwd got=%b want=0110", obs); end
    idle();
  endtask

  task automatic test_reg0();
    do_reset();
    set_dec(0, 1, 0, 1, 0, 1, 3);
    #1;
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL r0_first got=%b want=0100", obs); end
    tick();
    n_vec++; if (obs !== 4'b0100) begin n_bad++; $display("FAIL r0_second got=%b want=0100", obs); end
    idle();
  endtask

  task automatic test_perf();
    logic [31:0] exp_cnt;
    do_reset();
    set_dec(0, 0, 0, 0, 6, 1, 0);
    tick();
    set_dec(0, 0, 0, 0, 6, 1, 0);
    tick();
    tick();
    tick();
    idle();
    #1;
`ifdef SCOREBOARD_PERF_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    n_vec++; if (perf_stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL perf_three got=%0d want=%0d", perf_stall_cnt, exp_cnt); end
`ifdef SCOREBOARD_PERF_EN
    force dut.perf_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_q;
    set_dec(0, 0, 0, 0, 6, 1, 0);
    tick();
    idle();
    #1;
    n_vec++; if (perf_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL perf_wrap got=%0d want=0", perf_stall_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_flush();
    test_reg0();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
